// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the game sequencer slice. This package
//               holds the FSM state encoding, the score width and the
//               saturating two-digit BCD increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Fixed encodings. These codes are visible on the state output port.
    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_READY   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_DYING   = 3'd3,
        ST_OVER    = 3'd4
    } game_state_t;

    // Two packed BCD digits.
    localparam int c_BCD_WIDTH = 8;

    // Returns value + 1 in BCD. The result holds at 99 instead of wrapping.
    function automatic logic [c_BCD_WIDTH-1:0] bcd_sat_inc(
        input logic [c_BCD_WIDTH-1:0] value
    );
        logic [c_BCD_WIDTH-1:0] result;
        if (value == 8'h99) begin
            result = value;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter
// Description : Two-digit BCD counter. It increments with saturation at 99
//               and has a synchronous clear. The clear has priority over the
//               increment.
// Ports       : clk     - system clock
//               rst     - asynchronous active-high reset
//               i_clr   - synchronous clear to 0x00
//               i_inc   - increment request (one per cycle)
//               o_value - current count, two BCD digits
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter
    import game_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_inc,
    output logic [c_BCD_WIDTH-1:0] o_value
);

    logic [c_BCD_WIDTH-1:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= bcd_sat_inc(r_value);
        end
    end

    assign o_value = r_value;

endmodule : bcd_counter
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Top-level game flow controller for a flappy-style game. The
//               block derives a frame tick from v_sync and a clean press pulse
//               from the raw button. It runs the
//               ATTRACT/READY/PLAY/DYING/OVER state machine, keeps the BCD
//               score and produces the physics strobes and the game-over blink.
// Options     : HISCORE_EN - when defined, keep a best-score register that is
//               updated on DYING->OVER. When undefined, best_bcd is 0x00.
// Ports       : clk         - 25 MHz pixel clock
//               rst         - asynchronous active-high reset
//               v_sync      - VGA vertical sync level (active low)
//               button      - raw asynchronous game button
//               collision   - overlap flag from the datapath (level)
//               pipe_passed - one-cycle pulse per cleared pipe
//               state       - current state code
//               frame_en    - physics/scroll update strobe (PLAY)
//               fall_en     - gravity-only strobe (DYING)
//               flap        - one-cycle upward impulse
//               score_bcd   - current score, two BCD digits
//               best_bcd    - best score, two BCD digits
//               blink       - game-over text blink enable
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
    import game_pkg::*;
#(
    parameter int DYING_FRAMES     = 30,
    parameter int OVER_HOLD_FRAMES = 60,
    parameter int BLINK_FRAMES     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   v_sync,
    input  logic                   button,
    input  logic                   collision,
    input  logic                   pipe_passed,
    output logic [2:0]             state,
    output logic                   frame_en,
    output logic                   fall_en,
    output logic                   flap,
    output logic [c_BCD_WIDTH-1:0] score_bcd,
    output logic [c_BCD_WIDTH-1:0] best_bcd,
    output logic                   blink
);

    // The counters must be able to hold the largest terminal count itself.
    localparam int c_MAX_AB     = (DYING_FRAMES > OVER_HOLD_FRAMES) ? DYING_FRAMES : OVER_HOLD_FRAMES;
    localparam int c_MAX_FRAMES = (c_MAX_AB > BLINK_FRAMES) ? c_MAX_AB : BLINK_FRAMES;
    localparam int c_CNT_W      = $clog2(c_MAX_FRAMES + 1);

    // ------------------------------------------------------------------
    // Frame tick: high for one cycle after the registered falling edge
    // of v_sync.
    // ------------------------------------------------------------------
    logic r_vs_q;
    logic r_vs_qq;
    logic w_frame_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_q  <= 1'b0;
            r_vs_qq <= 1'b0;
        end else begin
            r_vs_q  <= v_sync;
            r_vs_qq <= r_vs_q;
        end
    end

    assign w_frame_tick = r_vs_qq & ~r_vs_q;

    // ------------------------------------------------------------------
    // Button: two-flop synchroniser followed by a registered rising-edge
    // detector. The press pulse appears on the third clk edge after the
    // input rises.
    // ------------------------------------------------------------------
    logic r_btn_s1;
    logic r_btn_s2;
    logic r_btn_d;
    logic r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
            r_btn_d  <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_btn_s1 <= button;
            r_btn_s2 <= r_btn_s1;
            r_btn_d  <= r_btn_s2;
            r_press  <= r_btn_s2 & ~r_btn_d;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    game_state_t          r_state;
    game_state_t          w_state_next;
    logic [c_CNT_W-1:0]   r_frame_cnt;   // DYING duration / OVER hold
    logic [c_CNT_W-1:0]   r_blink_cnt;
    logic                 r_blink;
    logic                 r_flap_play;   // registered flap for presses in PLAY
    logic                 w_hold_done;
    logic                 w_frame_en;
    logic                 w_fall_en;
    logic                 w_flap;
    logic                 w_score_clr;
    logic                 w_score_inc;

    assign w_hold_done = (r_frame_cnt == c_CNT_W'(OVER_HOLD_FRAMES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ATTRACT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_en   = 1'b0;
        w_fall_en    = 1'b0;
        w_flap       = 1'b0;
        w_score_clr  = 1'b0;
        w_score_inc  = 1'b0;
        case (r_state)
            ST_ATTRACT: begin
                if (r_press) begin
                    w_state_next = ST_READY;
                    w_score_clr  = 1'b1;
                end
            end
            ST_READY: begin
                // The launching press flaps during the transition cycle.
                if (r_press) begin
                    w_state_next = ST_PLAY;
                    w_flap       = 1'b1;
                end
            end
            ST_PLAY: begin
                w_frame_en = w_frame_tick;
                w_flap     = r_flap_play;
                // A collision is qualified only by a frame tick. When it
                // fires, it takes priority over a same-cycle pipe pass.
                if (collision && w_frame_tick) begin
                    w_state_next = ST_DYING;
                end else if (pipe_passed) begin
                    w_score_inc = 1'b1;
                end
            end
            ST_DYING: begin
                w_fall_en = w_frame_tick;
                if (w_frame_tick && (r_frame_cnt == c_CNT_W'(DYING_FRAMES - 1))) begin
                    w_state_next = ST_OVER;
                end
            end
            ST_OVER: begin
                if (r_press && w_hold_done) begin
                    w_state_next = ST_READY;
                    w_score_clr  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_ATTRACT;
            end
        endcase
    end

    // Frame and blink counters restart on every state change. The blink
    // phase starts high only when the next state is OVER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_state_next != r_state) begin
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
            r_blink     <= (w_state_next == ST_OVER);
        end else if (w_frame_tick) begin
            if (r_state == ST_DYING) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (r_state == ST_OVER) begin
                if (!w_hold_done) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
                if (r_blink_cnt == c_CNT_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // A press during PLAY flaps one cycle later. The flap output is gated by
    // state, so a press that arrives as PLAY is left cannot leak into DYING.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flap_play <= 1'b0;
        end else begin
            r_flap_play <= (r_state == ST_PLAY) && r_press;
        end
    end

    // ------------------------------------------------------------------
    // Score and best score
    // ------------------------------------------------------------------
    bcd_counter u_score (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_score_clr),
        .i_inc   (w_score_inc),
        .o_value (score_bcd)
    );

`ifdef HISCORE_EN
    logic [c_BCD_WIDTH-1:0] r_best;

    // A plain binary compare is correct for packed BCD digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best <= '0;
        end else if ((r_state == ST_DYING) && (w_state_next == ST_OVER) && (score_bcd > r_best)) begin
            r_best <= score_bcd;
        end
    end

    assign best_bcd = r_best;
`else
    assign best_bcd = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign state    = r_state;
    assign frame_en = w_frame_en;
    assign fall_en  = w_fall_en;
    assign flap     = w_flap;
    assign blink    = (r_state == ST_OVER) && r_blink;

endmodule : game_sequencer
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed self-checking bench for game_sequencer. It plays
//               several games through all states, covering the press latency,
//               score saturation, collision qualification, DYING length, blink
//               and hold timing, the best score, and the asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    logic       clk;
    logic       rst;
    logic       v_sync;
    logic       button;
    logic       collision;
    logic       pipe_passed;
    logic [2:0] state;
    logic       frame_en;
    logic       fall_en;
    logic       flap;
    logic [7:0] score_bcd;
    logic [7:0] best_bcd;
    logic       blink;

    int n_checks = 0;
    int n_errors = 0;
    int n_fall   = 0;
    int n_fe     = 0;

    game_sequencer #(
        .DYING_FRAMES     (30),
        .OVER_HOLD_FRAMES (60),
        .BLINK_FRAMES     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .v_sync      (v_sync),
        .button      (button),
        .collision   (collision),
        .pipe_passed (pipe_passed),
        .state       (state),
        .frame_en    (frame_en),
        .fall_en     (fall_en),
        .flap        (flap),
        .score_bcd   (score_bcd),
        .best_bcd    (best_bcd),
        .blink       (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One v_sync low pulse. The tick is high in the cycle after the first
    // edge, and the strobes are sampled there.
    task automatic do_frame();
        v_sync = 1'b0;
        cyc(1);
        if (fall_en)  n_fall++;
        if (frame_en) n_fe++;
        cyc(1);
        v_sync = 1'b1;
        cyc(2);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    // Frame with collision and pipe_passed both high in the tick cycle.
    task automatic frame_collide();
        v_sync = 1'b0;
        cyc(1);
        collision   = 1'b1;
        pipe_passed = 1'b1;
        cyc(1);
        collision   = 1'b0;
        pipe_passed = 1'b0;
        v_sync      = 1'b1;
        cyc(2);
    endtask

    // f0: flap in the press cycle (3rd edge after the rise); f1/f2 follow.
    task automatic do_press(output logic f0, output logic f1, output logic f2, output logic [2:0] st0);
        button = 1'b1;
        cyc(3);
        f0  = flap;
        st0 = state;
        cyc(1);
        f1 = flap;
        cyc(1);
        f2 = flap;
        button = 1'b0;
        cyc(3);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pipe_passed = 1'b1;
            cyc(1);
            pipe_passed = 1'b0;
            cyc(1);
        end
    endtask

    task automatic check_best(input string tag, input logic [7:0] exp_hi);
`ifdef HISCORE_EN
        chk(tag, best_bcd, exp_hi);
`else
        chk(tag, best_bcd, 8'h00);
`endif
    endtask

    // Plays from READY through collision, DYING and the full OVER hold, then
    // restarts. Pipe passes are counted only while in PLAY.
    task automatic play_game(input int n_pipes, input logic [7:0] exp_score, input logic [7:0] exp_best);
        logic f0, f1, f2;
        logic [2:0] st0;
        do_press(f0, f1, f2, st0);
        chk("game_play", {5'd0, state}, 8'd2);
        pulses(n_pipes);
        chk("game_score", score_bcd, exp_score);
        frame_collide();
        chk("game_dying", {5'd0, state}, 8'd3);
        frames(30);
        chk("game_over", {5'd0, state}, 8'd4);
        check_best("game_best", exp_best);
        frames(60);
        do_press(f0, f1, f2, st0);
        chk("game_restart", {5'd0, state}, 8'd1);
    endtask

    initial begin
        logic f0, f1, f2;
        logic [2:0] st0;

        rst = 1'b1; v_sync = 1'b1; button = 1'b0; collision = 1'b0; pipe_passed = 1'b0;
        cyc(3);
        chk("rst_state", {5'd0, state}, 8'd0);
        chk("rst_score", score_bcd, 8'h00);
        chk("rst_best", best_bcd, 8'h00);
        chk("rst_strobes", {4'd0, frame_en, fall_en, flap, blink}, 8'h00);
        rst = 1'b0;
        cyc(2);

        // ATTRACT: no frame strobe; press -> READY.
        n_fe = 0;
        do_frame();
        chk("attract_no_frame_en", n_fe[7:0], 8'd0);
        do_press(f0, f1, f2, st0);
        chk("attract_flap", {5'd0, f0, f1, f2}, 8'd0);
        chk("attract_to_ready", {5'd0, state}, 8'd1);

        // READY: the press cycle flaps and starts PLAY on the next edge.
        do_press(f0, f1, f2, st0);
        chk("ready_press_flap", {7'd0, f0}, 8'd1);
        chk("ready_press_state", {5'd0, st0}, 8'd1);
        chk("ready_flap_single", {6'd0, f1, f2}, 8'd0);
        chk("ready_to_play", {5'd0, state}, 8'd2);

        // PLAY: frame_en follows the tick; a press flaps one cycle later.
        n_fe = 0;
        do_frame();
        chk("play_frame_en", n_fe[7:0], 8'd1);
        do_press(f0, f1, f2, st0);
        chk("play_flap_delay", {5'd0, f0, f1, f2}, 8'b010);

        // Game A: 7 pipes, collision off-tick ignored, collision on tick wins.
        pulses(7);
        chk("score_07", score_bcd, 8'h07);
        collision = 1'b1;
        cyc(3);
        collision = 1'b0;
        chk("collision_off_tick", {5'd0, state}, 8'd2);
        frame_collide();
        chk("collision_on_tick", {5'd0, state}, 8'd3);
        chk("collision_no_inc", score_bcd, 8'h07);
        chk("dying_no_blink", {7'd0, blink}, 8'd0);

        n_fall = 0;
        n_fe   = 0;
        frames(29);
        chk("dying_29", {5'd0, state}, 8'd3);
        frames(1);
        chk("dying_to_over", {5'd0, state}, 8'd4);
        chk("dying_fall_count", n_fall[7:0], 8'd30);
        chk("dying_no_frame_en", n_fe[7:0], 8'd0);
        chk("over_blink_entry", {7'd0, blink}, 8'd1);
        check_best("best_07", 8'h07);

        frames(15);
        chk("blink_tick15", {7'd0, blink}, 8'd1);
        frames(1);
        chk("blink_tick16", {7'd0, blink}, 8'd0);
        frames(43);
        chk("blink_tick59", {7'd0, blink}, 8'd0);
        do_press(f0, f1, f2, st0);
        chk("over_press_59_ignored", {5'd0, state}, 8'd4);
        frames(2);
        do_press(f0, f1, f2, st0);
        chk("over_press_61", {5'd0, state}, 8'd1);
        chk("restart_score_clr", score_bcd, 8'h00);
        chk("ready_no_blink", {7'd0, blink}, 8'd0);

        // Game B raises the best score; Game C does not lower it.
        play_game(12, 8'h12, 8'h12);
        play_game(3, 8'h03, 8'h12);

        // Reset mid-PLAY with score 0x05 while a frame tick is active.
        do_press(f0, f1, f2, st0);
        pulses(5);
        chk("pre_rst_score", score_bcd, 8'h05);
        v_sync = 1'b0;
        cyc(1);
        chk("pre_rst_frame_en", {7'd0, frame_en}, 8'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_state", {5'd0, state}, 8'd0);
        chk("async_rst_score", score_bcd, 8'h00);
        chk("async_rst_strobes", {5'd0, frame_en, fall_en, flap}, 8'd0);
        v_sync = 1'b1;
        cyc(2);
        rst = 1'b0;
        chk("post_rst_best", best_bcd, 8'h00);
        cyc(1);
        chk("post_rst_strobes", {5'd0, frame_en, fall_en, flap}, 8'd0);
        cyc(2);
        chk("post_rst_state", {5'd0, state}, 8'd0);

        // Game E: score saturation at 0x99.
        do_press(f0, f1, f2, st0);
        do_press(f0, f1, f2, st0);
        chk("sat_play", {5'd0, state}, 8'd2);
        pulses(99);
        chk("score_99", score_bcd, 8'h99);
        pulses(1);
        chk("score_sat", score_bcd, 8'h99);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_game_sequencer
`default_nettype wire
